alu_reservation_station: RTL and testbench

- Downstream neighbour of the instruction issuer: buffers ALU-class instructions whose source operands may still be pending in the ROB.
- Captures operand values from the common data bus (CDB) as producers complete.
- Issues the oldest fully-ready entry to the ALU through a registered valid/ready output stage.
- Its free-space signal drives the issuer's alu_wok.

---
 rtl/alu_reservation_station_if.sv | 67 ++++++
 rtl/alu_reservation_station.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_reservation_station_if
// Description : Issuer, CDB and ALU-issue bundle for the ALU reservation
//               station. The master drives instructions, broadcasts and
//               alu_ready. The slave is the station itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_reservation_station_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPERATOR_TYPES = 4,
    parameter int OPERAND_TYPES  = 2,
    parameter int ROB_ENTRY_LOG2 = 2
);
    // pipeline control
    logic                      flush;

    // issuer side
    logic                      isr_valid;
    logic                      rs_wok;
    logic [OPERATOR_TYPES-1:0] isr_operator;
    logic [OPERAND_TYPES-1:0]  isr_oprand;
    logic [DATA_WIDTH-1:0]     isr_imm;
    logic [DATA_WIDTH-1:0]     isr_cur_pc;
    logic                      isr_rs1_busy;
    logic                      isr_rs2_busy;
    logic [DATA_WIDTH-1:0]     isr_rs1_data;
    logic [DATA_WIDTH-1:0]     isr_rs2_data;
    logic [ROB_ENTRY_LOG2-1:0] isr_rs1_depend;
    logic [ROB_ENTRY_LOG2-1:0] isr_rs2_depend;
    logic [ROB_ENTRY_LOG2-1:0] isr_rob_entry;

    // common data bus
    logic                      cdb_valid;
    logic [ROB_ENTRY_LOG2-1:0] cdb_rob_id;
    logic [DATA_WIDTH-1:0]     cdb_data;

    // ALU issue side
    logic                      alu_valid;
    logic                      alu_ready;
    logic [OPERATOR_TYPES-1:0] alu_operator;
    logic [OPERAND_TYPES-1:0]  alu_oprand;
    logic [DATA_WIDTH-1:0]     alu_imm;
    logic [DATA_WIDTH-1:0]     alu_cur_pc;
    logic [DATA_WIDTH-1:0]     alu_rs1_data;
    logic [DATA_WIDTH-1:0]     alu_rs2_data;
    logic [ROB_ENTRY_LOG2-1:0] alu_rob_entry;

    modport master (
        output flush, isr_valid, isr_operator, isr_oprand, isr_imm, isr_cur_pc,
               isr_rs1_busy, isr_rs2_busy, isr_rs1_data, isr_rs2_data,
               isr_rs1_depend, isr_rs2_depend, isr_rob_entry,
               cdb_valid, cdb_rob_id, cdb_data, alu_ready,
        input  rs_wok, alu_valid, alu_operator, alu_oprand, alu_imm, alu_cur_pc,
               alu_rs1_data, alu_rs2_data, alu_rob_entry
    );

    modport slave (
        input  flush, isr_valid, isr_operator, isr_oprand, isr_imm, isr_cur_pc,
               isr_rs1_busy, isr_rs2_busy, isr_rs1_data, isr_rs2_data,
               isr_rs1_depend, isr_rs2_depend, isr_rob_entry,
               cdb_valid, cdb_rob_id, cdb_data, alu_ready,
        output rs_wok, alu_valid, alu_operator, alu_oprand, alu_imm, alu_cur_pc,
               alu_rs1_data, alu_rs2_data, alu_rob_entry
    );
endinterface
`default_nettype wire

// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : alu_reservation_station
// Description : Buffers ALU instructions until both source operands are
//               known (captured from the issuer or the CDB), then issues the
//               oldest ready entry through a one-deep registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_reservation_station #(
    parameter int RS_ENTRY       = 4,
    parameter int ROB_ENTRY      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int OPERATOR_TYPES = 4,
    parameter int OPERAND_TYPES  = 2,
    parameter int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY)
) (
    input  wire logic CLK,
    input  wire logic RSTN,
    alu_reservation_station_if.slave bus
);

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [RS_ENTRY-1:0]       r_valid;
    logic [RS_ENTRY-1:0]       r_rs1_rdy;
    logic [RS_ENTRY-1:0]       r_rs2_rdy;
    // r_older[i][j] set means entry j was allocated before entry i
    logic [RS_ENTRY-1:0]       r_older      [RS_ENTRY];
    logic [OPERATOR_TYPES-1:0] r_operator   [RS_ENTRY];
    logic [OPERAND_TYPES-1:0]  r_oprand     [RS_ENTRY];
    logic [DATA_WIDTH-1:0]     r_imm        [RS_ENTRY];
    logic [DATA_WIDTH-1:0]     r_cur_pc     [RS_ENTRY];
    logic [ROB_ENTRY_LOG2-1:0] r_rob_entry  [RS_ENTRY];
    logic [ROB_ENTRY_LOG2-1:0] r_rs1_tag    [RS_ENTRY];
    logic [ROB_ENTRY_LOG2-1:0] r_rs2_tag    [RS_ENTRY];
    logic [DATA_WIDTH-1:0]     r_rs1_data   [RS_ENTRY];
    logic [DATA_WIDTH-1:0]     r_rs2_data   [RS_ENTRY];

    // Output stage
    logic                      r_alu_valid;
    logic [OPERATOR_TYPES-1:0] r_alu_operator;
    logic [OPERAND_TYPES-1:0]  r_alu_oprand;
    logic [DATA_WIDTH-1:0]     r_alu_imm;
    logic [DATA_WIDTH-1:0]     r_alu_cur_pc;
    logic [DATA_WIDTH-1:0]     r_alu_rs1_data;
    logic [DATA_WIDTH-1:0]     r_alu_rs2_data;
    logic [ROB_ENTRY_LOG2-1:0] r_alu_rob_entry;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [RS_ENTRY-1:0]       w_cand;
    logic [RS_ENTRY-1:0]       w_winner;
    logic [RS_ENTRY-1:0]       w_dealloc;
    logic [RS_ENTRY-1:0]       w_free_oh;
    logic [RS_ENTRY-1:0]       w_alloc;
    logic                      w_rs_wok;
    logic                      w_accept;
    logic                      w_load;
    logic                      w_rs1_hit;
    logic                      w_rs2_hit;
    logic                      w_new_rs1_rdy;
    logic                      w_new_rs2_rdy;
    logic [DATA_WIDTH-1:0]     w_new_rs1_data;
    logic [DATA_WIDTH-1:0]     w_new_rs2_data;

    logic [OPERATOR_TYPES-1:0] w_sel_operator;
    logic [OPERAND_TYPES-1:0]  w_sel_oprand;
    logic [DATA_WIDTH-1:0]     w_sel_imm;
    logic [DATA_WIDTH-1:0]     w_sel_cur_pc;
    logic [DATA_WIDTH-1:0]     w_sel_rs1_data;
    logic [DATA_WIDTH-1:0]     w_sel_rs2_data;
    logic [ROB_ENTRY_LOG2-1:0] w_sel_rob_entry;

    // Free space is judged on registered state only, so alu_ready never
    // reaches rs_wok combinationally.
    assign w_rs_wok  = ~&r_valid;
    assign w_accept  = bus.isr_valid & w_rs_wok & ~bus.flush;
    // Lowest clear bit of r_valid as a one-hot vector.
    assign w_free_oh = ~r_valid & (r_valid + RS_ENTRY'(1));
    assign w_alloc   = w_accept ? w_free_oh : '0;

    assign w_cand    = r_valid & r_rs1_rdy & r_rs2_rdy;

    // Oldest-ready pick: a candidate wins when no older entry is a candidate.
    generate
        for (genvar gi = 0; gi < RS_ENTRY; gi++) begin : g_select
            assign w_winner[gi] = w_cand[gi] & ~|(r_older[gi] & w_cand);
        end
    endgenerate

    assign w_load    = (~r_alu_valid | bus.alu_ready) & (|w_cand);
    assign w_dealloc = w_load ? w_winner : '0;

    // An operand still pending in the ROB may be produced on this very cycle.
    assign w_rs1_hit      = bus.cdb_valid & (bus.cdb_rob_id == bus.isr_rs1_depend);
    assign w_rs2_hit      = bus.cdb_valid & (bus.cdb_rob_id == bus.isr_rs2_depend);
    assign w_new_rs1_rdy  = ~bus.isr_rs1_busy | w_rs1_hit;
    assign w_new_rs2_rdy  = ~bus.isr_rs2_busy | w_rs2_hit;
    assign w_new_rs1_data = (bus.isr_rs1_busy & w_rs1_hit) ? bus.cdb_data : bus.isr_rs1_data;
    assign w_new_rs2_data = (bus.isr_rs2_busy & w_rs2_hit) ? bus.cdb_data : bus.isr_rs2_data;

    // One-hot mux of the winning entry's payload.
    always_comb begin
        w_sel_operator  = '0;
        w_sel_oprand    = '0;
        w_sel_imm       = '0;
        w_sel_cur_pc    = '0;
        w_sel_rs1_data  = '0;
        w_sel_rs2_data  = '0;
        w_sel_rob_entry = '0;
        for (int i = 0; i < RS_ENTRY; i++) begin
            if (w_winner[i]) begin
                w_sel_operator  = w_sel_operator  | r_operator[i];
                w_sel_oprand    = w_sel_oprand    | r_oprand[i];
                w_sel_imm       = w_sel_imm       | r_imm[i];
                w_sel_cur_pc    = w_sel_cur_pc    | r_cur_pc[i];
                w_sel_rs1_data  = w_sel_rs1_data  | r_rs1_data[i];
                w_sel_rs2_data  = w_sel_rs2_data  | r_rs2_data[i];
                w_sel_rob_entry = w_sel_rob_entry | r_rob_entry[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry update: flush, CDB wakeup, allocation, issue deallocation
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_valid   <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
            for (int i = 0; i < RS_ENTRY; i++) begin
                r_older[i]     <= '0;
                r_operator[i]  <= '0;
                r_oprand[i]    <= '0;
                r_imm[i]       <= '0;
                r_cur_pc[i]    <= '0;
                r_rob_entry[i] <= '0;
                r_rs1_tag[i]   <= '0;
                r_rs2_tag[i]   <= '0;
                r_rs1_data[i]  <= '0;
                r_rs2_data[i]  <= '0;
            end
        end else if (bus.flush) begin
            r_valid <= '0;
            for (int i = 0; i < RS_ENTRY; i++) begin
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRY; i++) begin
                if (r_valid[i] && !r_rs1_rdy[i] && bus.cdb_valid &&
                    (r_rs1_tag[i] == bus.cdb_rob_id)) begin
                    r_rs1_rdy[i]  <= 1'b1;
                    r_rs1_data[i] <= bus.cdb_data;
                end
                if (r_valid[i] && !r_rs2_rdy[i] && bus.cdb_valid &&
                    (r_rs2_tag[i] == bus.cdb_rob_id)) begin
                    r_rs2_rdy[i]  <= 1'b1;
                    r_rs2_data[i] <= bus.cdb_data;
                end
                if (w_alloc[i]) begin
                    r_operator[i]  <= bus.isr_operator;
                    r_oprand[i]    <= bus.isr_oprand;
                    r_imm[i]       <= bus.isr_imm;
                    r_cur_pc[i]    <= bus.isr_cur_pc;
                    r_rob_entry[i] <= bus.isr_rob_entry;
                    r_rs1_tag[i]   <= bus.isr_rs1_depend;
                    r_rs2_tag[i]   <= bus.isr_rs2_depend;
                    r_rs1_rdy[i]   <= w_new_rs1_rdy;
                    r_rs2_rdy[i]   <= w_new_rs2_rdy;
                    r_rs1_data[i]  <= w_new_rs1_data;
                    r_rs2_data[i]  <= w_new_rs2_data;
                    // Everything still resident after this edge is older.
                    r_older[i]     <= r_valid & ~w_dealloc;
                end else begin
                    // Nobody is younger than the entry being allocated.
                    r_older[i]     <= r_older[i] & ~w_alloc;
                end
            end
            r_valid <= (r_valid & ~w_dealloc) | w_alloc;
        end
    end

    // Output stage: load the winner when empty or draining, else hold.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_alu_valid     <= 1'b0;
            r_alu_operator  <= '0;
            r_alu_oprand    <= '0;
            r_alu_imm       <= '0;
            r_alu_cur_pc    <= '0;
            r_alu_rs1_data  <= '0;
            r_alu_rs2_data  <= '0;
            r_alu_rob_entry <= '0;
        end else if (bus.flush) begin
            r_alu_valid <= 1'b0;
        end else if (w_load) begin
            r_alu_valid     <= 1'b1;
            r_alu_operator  <= w_sel_operator;
            r_alu_oprand    <= w_sel_oprand;
            r_alu_imm       <= w_sel_imm;
            r_alu_cur_pc    <= w_sel_cur_pc;
            r_alu_rs1_data  <= w_sel_rs1_data;
            r_alu_rs2_data  <= w_sel_rs2_data;
            r_alu_rob_entry <= w_sel_rob_entry;
        end else begin
            r_alu_valid <= r_alu_valid & ~bus.alu_ready;
        end
    end

    assign bus.rs_wok        = w_rs_wok;
    assign bus.alu_valid     = r_alu_valid;
    assign bus.alu_operator  = r_alu_operator;
    assign bus.alu_oprand    = r_alu_oprand;
    assign bus.alu_imm       = r_alu_imm;
    assign bus.alu_cur_pc    = r_alu_cur_pc;
    assign bus.alu_rs1_data  = r_alu_rs1_data;
    assign bus.alu_rs2_data  = r_alu_rs2_data;
    assign bus.alu_rob_entry = r_alu_rob_entry;

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_reservation_station
// Description : Self-checking bench for alu_reservation_station. A queue-free
//               entry model with allocation sequence numbers predicts the
//               outputs every cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_reservation_station;

    localparam int RS_ENTRY = 4;
    localparam int ROB_ENTRY = 4;
    localparam int DW  = 32;
    localparam int OPW = 4;
    localparam int ODW = 2;
    localparam int TW  = 2;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;

    alu_reservation_station_if #(
        .DATA_WIDTH(DW), .OPERATOR_TYPES(OPW), .OPERAND_TYPES(ODW), .ROB_ENTRY_LOG2(TW)
    ) bus ();

    alu_reservation_station #(
        .RS_ENTRY(RS_ENTRY), .ROB_ENTRY(ROB_ENTRY), .DATA_WIDTH(DW),
        .OPERATOR_TYPES(OPW), .OPERAND_TYPES(ODW), .ROB_ENTRY_LOG2(TW)
    ) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Behavioural model: each entry carries its allocation sequence number,
    // the oldest ready entry is simply the one with the smallest number.
    // ------------------------------------------------------------------
    typedef struct {
        bit              v;
        int unsigned     seq;
        logic [OPW-1:0]  op;
        logic [ODW-1:0]  opd;
        logic [DW-1:0]   imm;
        logic [DW-1:0]   pc;
        logic [TW-1:0]   rob;
        bit              r1;
        bit              r2;
        logic [TW-1:0]   t1;
        logic [TW-1:0]   t2;
        logic [DW-1:0]   d1;
        logic [DW-1:0]   d2;
    } ent_t;

    ent_t        m_e [RS_ENTRY];
    ent_t        m_out;
    bit          m_av;
    int unsigned m_seq;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < RS_ENTRY; i++) m_e[i].v = 1'b0;
        m_av  = 1'b0;
        m_seq = 0;
    endfunction

    function automatic bit model_full();
        bit f = 1'b1;
        for (int i = 0; i < RS_ENTRY; i++) if (!m_e[i].v) f = 1'b0;
        return f;
    endfunction

    // Advance the model across one clock edge using the inputs now driven.
    function automatic void model_step();
        bit          wok;
        int          win;
        int          k;
        int unsigned best;
        wok  = !model_full();
        win  = -1;
        k    = -1;
        best = 0;
        if (bus.flush) begin
            for (int i = 0; i < RS_ENTRY; i++) m_e[i].v = 1'b0;
            m_av = 1'b0;
            return;
        end
        for (int i = 0; i < RS_ENTRY; i++)
            if (m_e[i].v && m_e[i].r1 && m_e[i].r2 && (win < 0 || m_e[i].seq < best)) begin
                win  = i;
                best = m_e[i].seq;
            end
        for (int i = RS_ENTRY - 1; i >= 0; i--) if (!m_e[i].v) k = i;
        if ((!m_av || bus.alu_ready) && win >= 0) begin
            m_av      = 1'b1;
            m_out     = m_e[win];
            m_e[win].v = 1'b0;
        end else if (bus.alu_ready) begin
            m_av = 1'b0;
        end
        if (bus.cdb_valid)
            for (int i = 0; i < RS_ENTRY; i++) if (m_e[i].v) begin
                if (!m_e[i].r1 && m_e[i].t1 == bus.cdb_rob_id) begin
                    m_e[i].r1 = 1'b1; m_e[i].d1 = bus.cdb_data;
                end
                if (!m_e[i].r2 && m_e[i].t2 == bus.cdb_rob_id) begin
                    m_e[i].r2 = 1'b1; m_e[i].d2 = bus.cdb_data;
                end
            end
        if (bus.isr_valid && wok) begin
            m_e[k].v   = 1'b1;
            m_e[k].seq = m_seq;
            m_seq++;
            m_e[k].op  = bus.isr_operator;
            m_e[k].opd = bus.isr_oprand;
            m_e[k].imm = bus.isr_imm;
            m_e[k].pc  = bus.isr_cur_pc;
            m_e[k].rob = bus.isr_rob_entry;
            m_e[k].t1  = bus.isr_rs1_depend;
            m_e[k].t2  = bus.isr_rs2_depend;
            m_e[k].r1  = !bus.isr_rs1_busy ||
                         (bus.cdb_valid && bus.cdb_rob_id == bus.isr_rs1_depend);
            m_e[k].r2  = !bus.isr_rs2_busy ||
                         (bus.cdb_valid && bus.cdb_rob_id == bus.isr_rs2_depend);
            m_e[k].d1  = !bus.isr_rs1_busy ? bus.isr_rs1_data : bus.cdb_data;
            m_e[k].d2  = !bus.isr_rs2_busy ? bus.isr_rs2_data : bus.cdb_data;
        end
    endfunction

    // Compare the DUT outputs against the model after an edge.
    function automatic void check_cycle();
        chk("alu_valid", 64'(bus.alu_valid), 64'(m_av));
        chk("rs_wok", 64'(bus.rs_wok), 64'(!model_full()));
        if (m_av) begin
            chk("alu_operator",  64'(bus.alu_operator),  64'(m_out.op));
            chk("alu_oprand",    64'(bus.alu_oprand),    64'(m_out.opd));
            chk("alu_imm",       64'(bus.alu_imm),       64'(m_out.imm));
            chk("alu_cur_pc",    64'(bus.alu_cur_pc),    64'(m_out.pc));
            chk("alu_rs1_data",  64'(bus.alu_rs1_data),  64'(m_out.d1));
            chk("alu_rs2_data",  64'(bus.alu_rs2_data),  64'(m_out.d2));
            chk("alu_rob_entry", 64'(bus.alu_rob_entry), 64'(m_out.rob));
        end
    endfunction

    // One clock: model step, edge, compare, then drop one-cycle pulses.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_cycle();
        bus.isr_valid = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic set_accept(input int rob, input bit b1, input int dep1, input logic [DW-1:0] d1,
                              input bit b2, input int dep2, input logic [DW-1:0] d2);
        bus.isr_valid      = 1'b1;
        bus.isr_rob_entry  = TW'(rob);
        bus.isr_rs1_busy   = b1;
        bus.isr_rs1_depend = TW'(dep1);
        bus.isr_rs1_data   = d1;
        bus.isr_rs2_busy   = b2;
        bus.isr_rs2_depend = TW'(dep2);
        bus.isr_rs2_data   = d2;
        bus.isr_operator   = OPW'(rob + 3);
        bus.isr_oprand     = ODW'(rob);
        bus.isr_imm        = d1 ^ d2 ^ 32'h00A5_0000;
        bus.isr_cur_pc     = 32'h0000_1000 + 32'(rob * 4);
    endtask

    task automatic set_cdb(input int id, input logic [DW-1:0] data);
        bus.cdb_valid  = 1'b1;
        bus.cdb_rob_id = TW'(id);
        bus.cdb_data   = data;
    endtask

    initial begin
        bus.flush = 0; bus.isr_valid = 0; bus.isr_operator = 0; bus.isr_oprand = 0;
        bus.isr_imm = 0; bus.isr_cur_pc = 0; bus.isr_rs1_busy = 0; bus.isr_rs2_busy = 0;
        bus.isr_rs1_data = 0; bus.isr_rs2_data = 0; bus.isr_rs1_depend = 0;
        bus.isr_rs2_depend = 0; bus.isr_rob_entry = 0; bus.cdb_valid = 0;
        bus.cdb_rob_id = 0; bus.cdb_data = 0; bus.alu_ready = 1;
        model_reset();

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("reset alu_valid", 64'(bus.alu_valid), 64'h0);
        chk("reset rs1_data", 64'(bus.alu_rs1_data), 64'h0);
        chk("reset rob_entry", 64'(bus.alu_rob_entry), 64'h0);
        chk("reset pc", 64'(bus.alu_cur_pc), 64'h0);
        RSTN = 1'b1;
        tick();
        chk("post-reset rs_wok", 64'(bus.rs_wok), 64'h1);

        // Ready-operand issue
        set_accept(2, 0, 0, 32'h5, 0, 0, 32'h7);
        tick();
        chk("s1 valid after accept", 64'(bus.alu_valid), 64'h0);
        tick();
        chk("s1 valid", 64'(bus.alu_valid), 64'h1);
        chk("s1 rs1", 64'(bus.alu_rs1_data), 64'h5);
        chk("s1 rs2", 64'(bus.alu_rs2_data), 64'h7);
        chk("s1 rob", 64'(bus.alu_rob_entry), 64'h2);
        chk("s1 rs_wok", 64'(bus.rs_wok), 64'h1);
        tick();
        chk("s1 drained", 64'(bus.alu_valid), 64'h0);

        // CDB wakeup
        set_accept(0, 1, 3, 32'h0, 0, 0, 32'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s2 no early issue", 64'(bus.alu_valid), 64'h0);
        end
        set_cdb(3, 32'hDEAD);
        tick();
        chk("s2 woken not yet issued", 64'(bus.alu_valid), 64'h0);
        tick();
        chk("s2 valid", 64'(bus.alu_valid), 64'h1);
        chk("s2 rs1", 64'(bus.alu_rs1_data), 64'hDEAD);
        tick();

        // Same-cycle bypass
        set_accept(1, 0, 0, 32'h11, 1, 1, 32'h0);
        set_cdb(1, 32'h42);
        tick();
        chk("s3 valid after accept", 64'(bus.alu_valid), 64'h0);
        tick();
        chk("s3 valid", 64'(bus.alu_valid), 64'h1);
        chk("s3 rs2", 64'(bus.alu_rs2_data), 64'h42);
        tick();

        // Age order: A waits on tag 0, B and C ready, A woken with C's accept
        set_accept(1, 1, 0, 32'h0, 0, 0, 32'hA2);
        tick();
        set_accept(2, 0, 0, 32'hB1, 0, 0, 32'hB2);
        tick();
        set_accept(3, 0, 0, 32'hC1, 0, 0, 32'hC2);
        set_cdb(0, 32'h99);
        tick();
        chk("s4 first B", 64'(bus.alu_rob_entry), 64'h2);
        tick();
        chk("s4 second A", 64'(bus.alu_rob_entry), 64'h1);
        chk("s4 A rs1", 64'(bus.alu_rs1_data), 64'h99);
        tick();
        chk("s4 third C", 64'(bus.alu_rob_entry), 64'h3);
        tick();
        chk("s4 drained", 64'(bus.alu_valid), 64'h0);

        // Full and backpressure
        bus.alu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_accept(i % 4, 0, 0, 32'h100 + 32'(i), 0, 0, 32'h200 + 32'(i));
            tick();
        end
        chk("s5 full", 64'(bus.rs_wok), 64'h0);
        chk("s5 held valid", 64'(bus.alu_valid), 64'h1);
        chk("s5 held rs1", 64'(bus.alu_rs1_data), 64'h100);
        tick();
        tick();
        chk("s5 stable rs1", 64'(bus.alu_rs1_data), 64'h100);
        bus.alu_ready = 1'b1;
        tick();
        bus.alu_ready = 1'b0;
        chk("s5 rs_wok after issue", 64'(bus.rs_wok), 64'h1);
        chk("s5 next rs1", 64'(bus.alu_rs1_data), 64'h101);
        tick();
        chk("s5 next held", 64'(bus.alu_rs1_data), 64'h101);

        // Flush
        set_accept(2, 1, 2, 32'h0, 0, 0, 32'h0);
        tick();
        chk("s6 full before flush", 64'(bus.rs_wok), 64'h0);
        bus.flush = 1'b1;
        tick();
        chk("s6 flush valid", 64'(bus.alu_valid), 64'h0);
        chk("s6 flush rs_wok", 64'(bus.rs_wok), 64'h1);
        bus.alu_ready = 1'b1;
        set_cdb(2, 32'h77);
        tick();
        chk("s6 no issue 1", 64'(bus.alu_valid), 64'h0);
        tick();
        chk("s6 no issue 2", 64'(bus.alu_valid), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.alu_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 9) < 6)
                set_accept($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                           $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 1) == 1)
                set_cdb($urandom_range(0, 3), $urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
